mem_port_arbiter: RTL

- Shares one single-ported unified memory between the instruction-fetch path (IF) and the data-memory path (DM) of the multi-cycle CPU.
- Sits between the datapath's PC/IR fetch logic and its load/store logic on one side, and the physical memory on the other.
- Serialises accesses with a req/ack handshake, alternates priority under contention, and aborts stuck accesses with a timeout.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/arb2_alternating.sv | 31 +++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared types and constants for the IF/DM memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

  localparam int c_DEFAULT_AW    = 32;
  localparam int c_DEFAULT_DW    = 32;
  localparam int c_CNT_W         = 8;
  localparam int c_TIMEOUT_RDATA = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

endpackage

`default_nettype wire

// File: rtl/arb2_alternating.sv
// ============================================================================
// Module  : arb2_alternating
// Brief   : Combinational 2-way picker; on conflict grants the side that
//           did not win last time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module arb2_alternating
  import mem_arb_pkg::*;
(
  input  logic   i_elig_fetch,
  input  logic   i_elig_data,
  input  grant_e i_last_grant,
  output grant_e o_grant,
  output logic   o_valid
);

  always_comb begin
    o_valid = i_elig_fetch | i_elig_data;
    o_grant = GNT_FETCH;
    if (i_elig_fetch && i_elig_data) begin
      o_grant = (i_last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
    end else if (i_elig_data) begin
      o_grant = GNT_DATA;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Serialises instruction-fetch and data accesses onto one
//           single-ported memory with alternating priority and timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = c_DEFAULT_AW,
  parameter int DW      = c_DEFAULT_DW,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_ack,
  output logic [DW-1:0] o_if_rdata,
  input  logic          i_dm_req,
  input  logic          i_dm_we,
  input  logic [AW-1:0] i_dm_addr,
  input  logic [DW-1:0] i_dm_wdata,
  output logic          o_dm_ack,
  output logic [DW-1:0] o_dm_rdata,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ready,
  output logic          o_busy,
  output logic          o_err
);

  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);
  localparam logic [DW-1:0]      c_ABORT_DATA = DW'(c_TIMEOUT_RDATA);

  state_e               r_state;
  grant_e               r_last_grant;
  logic [c_CNT_W-1:0]   r_cnt;

  logic   w_elig_fetch;
  logic   w_elig_data;
  logic   w_valid;
  grant_e w_grant;
  logic   w_done;

  // A requester still seeing its own ack is ignored so the req drop after
  // completion cannot trigger a duplicate access.
  assign w_elig_fetch = i_if_req & ~o_if_ack;
  assign w_elig_data  = i_dm_req & ~o_dm_ack;
  assign w_done       = i_mem_ready | (r_cnt == c_TIMEOUT);

  arb2_alternating u_arb (
    .i_elig_fetch (w_elig_fetch),
    .i_elig_data  (w_elig_data),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= GNT_FETCH;
      r_cnt        <= '0;
      o_if_ack     <= 1'b0;
      o_dm_ack     <= 1'b0;
      o_if_rdata   <= '0;
      o_dm_rdata   <= '0;
      o_mem_en     <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_busy       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_if_ack <= 1'b0;
      o_dm_ack <= 1'b0;
      o_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            o_mem_en     <= 1'b1;
            o_busy       <= 1'b1;
            r_cnt        <= '0;
            r_last_grant <= w_grant;
            if (w_grant == GNT_DATA) begin
              r_state     <= ST_DATA;
              o_mem_addr  <= i_dm_addr;
              o_mem_we    <= i_dm_we;
              o_mem_wdata <= i_dm_wdata;
            end else begin
              r_state    <= ST_FETCH;
              o_mem_addr <= i_if_addr;
              o_mem_we   <= 1'b0;
            end
          end
        end

        ST_FETCH, ST_DATA: begin
          if (w_done) begin
            r_state  <= ST_IDLE;
            o_mem_en <= 1'b0;
            o_mem_we <= 1'b0;
            o_busy   <= 1'b0;
            o_err    <= ~i_mem_ready;
            if (r_state == ST_FETCH) begin
              o_if_ack   <= 1'b1;
              o_if_rdata <= i_mem_ready ? i_mem_rdata : c_ABORT_DATA;
            end else begin
              o_dm_ack <= 1'b1;
              // Aborted accesses clear the read register; stores leave it alone.
              if (!i_mem_ready) begin
                o_dm_rdata <= c_ABORT_DATA;
              end else if (!o_mem_we) begin
                o_dm_rdata <= i_mem_rdata;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          o_mem_en <= 1'b0;
          o_mem_we <= 1'b0;
          o_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
